// File: rtl/dmem_pkg.sv
// Shared types and constants for the pipelined data memory.
// Holds the controller state encoding and the legal read-latency range.
package dmem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } dmem_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Raw DW x 2**AW storage with one write port and a registered read port.
// Neither the storage nor the read register is reset.
module dmem_array #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] guts [2**AW];

    // Read-first: a same-edge write never leaks into the captured read.
    always_ff @(posedge clk) begin
        if (we) begin
            guts[waddr] <= wdata;
        end
        if (re) begin
            rdata <= guts[raddr];
        end
    end

endmodule

// File: rtl/dmem_pipe.sv
// Data memory with req/rdy handshake, 1- or 2-cycle registered reads and a
// clear sequencer that fills the array with CLR_VAL after reset or on clr.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int          DW      = 8,
    parameter int          AW      = 8,
    parameter int          RD_LAT  = 1,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] di,
    output logic          rdy,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          dbg_state
);

    generate
        if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
            $error("dmem_pipe: RD_LAT must be 1 or 2");
        end
    endgenerate

    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_LAST = {1'b0, {AW{1'b1}}};

    dmem_state_e   state;
    logic [AW:0]   clr_ptr;
    logic          acc_rd;
    logic          acc_wr;
    logic          arr_we;
    logic [AW-1:0] arr_waddr;
    logic [DW-1:0] arr_wdata;
    logic [DW-1:0] rdata;
    logic          rd_v1;

    // Handshake: a request is taken on an edge where req & rdy; the requester
    // holds req, we, addr and di stable until that edge.
    assign busy      = (state == CLEAR);
    assign rdy       = (state == IDLE) & ~clr;
    assign acc_rd    = req & rdy & ~we;
    assign acc_wr    = req & rdy & we;
    assign dbg_state = state;

    // rdy is low for the whole clear, so the sequencer owns the write port then.
    assign arr_we    = busy | acc_wr;
    assign arr_waddr = busy ? clr_ptr[AW-1:0] : addr;
    assign arr_wdata = busy ? CLR_VAL : di;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_ptr == PTR_LAST) begin
                        state   <= IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + PTR_ONE;
                    end
                end
                default: begin
                    if (clr) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
            endcase
        end
    end

    dmem_array #(
        .DW (DW),
        .AW (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (acc_rd),
        .raddr (addr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= acc_rd;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            logic [DW-1:0] dout_hold;

            // The array register is not reset, so the hold copy supplies dout at rest.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_hold <= '0;
                end else if (rd_v1) begin
                    dout_hold <= rdata;
                end
            end

            assign dout     = rd_v1 ? rdata : dout_hold;
            assign dout_vld = rd_v1;
        end else begin : g_lat2
            logic [DW-1:0] dout_q;
            logic          vld_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= rd_v1;
                    if (rd_v1) begin
                        dout_q <= rdata;
                    end
                end
            end

            assign dout     = dout_q;
            assign dout_vld = vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=2 instance share the same stimulus.
// Inputs change 1ns after posedge; outputs are sampled at that same point.
module tb_dmem_pipe;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] di;

    logic       busy1, rdy1, vld1, st1;
    logic [7:0] dout1;
    logic       busy2, rdy2, vld2, st2;
    logic [7:0] dout2;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_pipe #(.DW(8), .AW(8), .RD_LAT(1), .CLR_VAL(8'h00)) u_lat1 (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy1), .req(req), .we(we),
        .addr(addr), .di(di), .rdy(rdy1), .dout(dout1), .dout_vld(vld1),
        .dbg_state(st1)
    );

    dmem_pipe #(.DW(8), .AW(8), .RD_LAT(2), .CLR_VAL(8'h00)) u_lat2 (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy2), .req(req), .we(we),
        .addr(addr), .di(di), .rdy(rdy2), .dout(dout2), .dout_vld(vld2),
        .dbg_state(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        req  = r;
        we   = w;
        addr = a;
        di   = d;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d);
        tick();
        drive_idle();
    endtask

    // Counts busy cycles from now until both instances leave CLEAR.
    task automatic count_busy(input string tag);
        int n1 = 0;
        int n2 = 0;
        for (int i = 0; i < 1000 && (busy1 || busy2); i++) begin
            if (busy1) n1++;
            if (busy2) n2++;
            tick();
        end
        check({tag, " l1 busy cycles"}, n1, 256);
        check({tag, " l2 busy cycles"}, n2, 256);
        check({tag, " l1 idle state"}, {31'd0, st1}, 0);
        check({tag, " l2 idle state"}, {31'd0, st2}, 0);
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] e);
        check({tag, " l1 rdy"}, {31'd0, rdy1}, 1);
        drive(1'b1, 1'b0, a, 8'h00);
        tick();
        drive_idle();
        check({tag, " l1 vld"}, {31'd0, vld1}, 1);
        check({tag, " l1 dout"}, {24'd0, dout1}, {24'd0, e});
        check({tag, " l2 vld early"}, {31'd0, vld2}, 0);
        tick();
        check({tag, " l2 vld"}, {31'd0, vld2}, 1);
        check({tag, " l2 dout"}, {24'd0, dout2}, {24'd0, e});
        check({tag, " l1 vld drop"}, {31'd0, vld1}, 0);
        check({tag, " l1 hold"}, {24'd0, dout1}, {24'd0, e});
        tick();
        check({tag, " l2 vld drop"}, {31'd0, vld2}, 0);
        check({tag, " l2 hold"}, {24'd0, dout2}, {24'd0, e});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " l1 busy"}, {31'd0, busy1}, 1);
        check({tag, " l2 busy"}, {31'd0, busy2}, 1);
        check({tag, " l1 rdy"}, {31'd0, rdy1}, 0);
        check({tag, " l2 rdy"}, {31'd0, rdy2}, 0);
        check({tag, " l1 vld"}, {31'd0, vld1}, 0);
        check({tag, " l2 vld"}, {31'd0, vld2}, 0);
        check({tag, " l1 dout"}, {24'd0, dout1}, 0);
        check({tag, " l2 dout"}, {24'd0, dout2}, 0);
    endtask

    initial begin
        reset = 1'b1;
        clr   = 1'b0;
        drive_idle();

        // Power-up reset, then the automatic clear.
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b0;
        count_busy("por clear");
        read_check("rd 00", 8'h00, 8'h00);
        read_check("rd 7f", 8'h7F, 8'h00);
        read_check("rd ff", 8'hFF, 8'h00);

        // Write then read the same address on the next cycle.
        write_word(8'h10, 8'hA5);
        check("wr no l1 vld", {31'd0, vld1}, 0);
        check("wr no l2 vld", {31'd0, vld2}, 0);
        read_check("raw 10", 8'h10, 8'hA5);

        // Three back-to-back reads.
        write_word(8'h01, 8'h11);
        write_word(8'h02, 8'h22);
        write_word(8'h03, 8'h33);
        drive(1'b1, 1'b0, 8'h01, 8'h00);
        tick();
        check("b2b l1 v0", {31'd0, vld1}, 1);
        check("b2b l1 d0", {24'd0, dout1}, 32'h11);
        drive(1'b1, 1'b0, 8'h02, 8'h00);
        tick();
        check("b2b l1 v1", {31'd0, vld1}, 1);
        check("b2b l1 d1", {24'd0, dout1}, 32'h22);
        check("b2b l2 v0", {31'd0, vld2}, 1);
        check("b2b l2 d0", {24'd0, dout2}, 32'h11);
        drive(1'b1, 1'b0, 8'h03, 8'h00);
        tick();
        drive_idle();
        check("b2b l1 v2", {31'd0, vld1}, 1);
        check("b2b l1 d2", {24'd0, dout1}, 32'h33);
        check("b2b l2 v1", {31'd0, vld2}, 1);
        check("b2b l2 d1", {24'd0, dout2}, 32'h22);
        tick();
        check("b2b l1 end", {31'd0, vld1}, 0);
        check("b2b l1 hold", {24'd0, dout1}, 32'h33);
        check("b2b l2 v2", {31'd0, vld2}, 1);
        check("b2b l2 d2", {24'd0, dout2}, 32'h33);
        tick();
        check("b2b l2 end", {31'd0, vld2}, 0);

        // clr colliding with a write: write refused, array cleared.
        clr = 1'b1;
        drive(1'b1, 1'b1, 8'h20, 8'h55);
        #1;
        check("clr coll l1 rdy", {31'd0, rdy1}, 0);
        check("clr coll l2 rdy", {31'd0, rdy2}, 0);
        tick();
        clr = 1'b0;
        drive_idle();
        count_busy("clr");
        read_check("after clr 20", 8'h20, 8'h00);
        read_check("after clr 10", 8'h10, 8'h00);

        // A read in flight when clr is taken returns pre-clear data.
        write_word(8'h40, 8'h3C);
        drive(1'b1, 1'b0, 8'h40, 8'h00);
        tick();
        drive_idle();
        clr = 1'b1;
        check("flight l1 vld", {31'd0, vld1}, 1);
        check("flight l1 dout", {24'd0, dout1}, 32'h3C);
        tick();
        clr = 1'b0;
        check("flight l2 vld", {31'd0, vld2}, 1);
        check("flight l2 dout", {24'd0, dout2}, 32'h3C);
        count_busy("flight clr");

        // Reset with a read in flight drops it.
        write_word(8'h40, 8'h3C);
        read_check("pre rst 40", 8'h40, 8'h3C);
        drive(1'b1, 1'b0, 8'h40, 8'h00);
        tick();
        drive_idle();
        reset = 1'b1;
        #1;
        check_reset_outputs("rst mid rd");
        tick();
        tick();
        check("rst drop l2 vld", {31'd0, vld2}, 0);
        reset = 1'b0;
        count_busy("rst mid rd");

        // Reset at clear cycle 100 restarts a full clear.
        write_word(8'h40, 8'h3C);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (100) tick();
        check("mid clr l1 busy", {31'd0, busy1}, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst mid clr");
        tick();
        reset = 1'b0;
        count_busy("rst mid clr");
        read_check("after rst 40", 8'h40, 8'h00);

        // Write behind a read to the same address.
        write_word(8'h30, 8'h66);
        drive(1'b1, 1'b0, 8'h30, 8'h00);
        tick();
        drive(1'b1, 1'b1, 8'h30, 8'h77);
        check("wbr l1 dout", {24'd0, dout1}, 32'h66);
        check("wbr l1 vld", {31'd0, vld1}, 1);
        tick();
        drive_idle();
        check("wbr l2 vld", {31'd0, vld2}, 1);
        check("wbr l2 dout", {24'd0, dout2}, 32'h66);
        check("wbr l1 no vld", {31'd0, vld1}, 0);
        tick();
        read_check("wbr new", 8'h30, 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
